// File: rtl/ecc_apb_driver_pkg.sv
// ============================================================================
// Module  : ecc_apb_driver_pkg
// Brief   : Register offsets, command/status codes and state encodings shared
//           by the ECC APB driver and its write engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_apb_driver_pkg;

  localparam logic [1:0] c_REG_CTRL           = 2'b00;
  localparam logic [1:0] c_REG_DATA_IN        = 2'b01;
  localparam logic [1:0] c_REG_CODEWORD_WIDTH = 2'b10;
  localparam logic [1:0] c_REG_NOISE          = 2'b11;

  localparam logic [1:0] c_MODE_ENCODE  = 2'b00;
  localparam logic [1:0] c_MODE_DECODE  = 2'b01;
  localparam logic [1:0] c_MODE_FULL    = 2'b10;
  localparam logic [1:0] c_MODE_ILLEGAL = 2'b11;

  localparam logic [1:0] c_WIDTH_SMALL   = 2'b00;
  localparam logic [1:0] c_WIDTH_MEDIUM  = 2'b01;
  localparam logic [1:0] c_WIDTH_LARGE   = 2'b10;
  localparam logic [1:0] c_WIDTH_ILLEGAL = 2'b11;

  localparam logic [1:0] c_STATUS_OK      = 2'b00;
  localparam logic [1:0] c_STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] c_STATUS_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WP_IDLE   = 2'd0,
    WP_SETUP  = 2'd1,
    WP_ACCESS = 2'd2
  } wp_phase_t;

  // CTRL is always the final write because it kicks off the ECC operation.
  function automatic logic [1:0] next_reg(input logic [1:0] cur, input logic [1:0] mode);
    case (cur)
      c_REG_CODEWORD_WIDTH: return c_REG_DATA_IN;
      c_REG_DATA_IN:        return (mode == c_MODE_FULL) ? c_REG_NOISE : c_REG_CTRL;
      default:              return c_REG_CTRL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_apb_driver_if.sv
// ============================================================================
// Module  : ecc_apb_driver_if
// Brief   : Command, result, APB and ECC-status signals of the ECC APB driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ecc_apb_driver_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [1:0]                 cmd_mode;
  logic [1:0]                 cmd_width;
  logic [AMBA_WORD-1:0]       cmd_data;
  logic [AMBA_WORD-1:0]       cmd_noise;
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       operation_done;
  logic [1:0]                 num_of_errors;
  logic                       res_valid;
  logic                       res_ready;
  logic [DATA_WIDTH-1:0]      res_data;
  logic [1:0]                 res_errors;
  logic [1:0]                 res_status;
  logic                       busy;

  modport master (
    input  cmd_valid, cmd_mode, cmd_width, cmd_data, cmd_noise,
    input  data_out, operation_done, num_of_errors, res_ready,
    output cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    output res_valid, res_data, res_errors, res_status, busy
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_width, cmd_data, cmd_noise,
    output data_out, operation_done, num_of_errors, res_ready,
    input  cmd_ready, PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    input  res_valid, res_data, res_errors, res_status, busy
  );
endinterface

`default_nettype wire

// File: rtl/ecc_apb_driver_write_port.sv
// ============================================================================
// Module  : ecc_apb_write_port
// Brief   : Two-phase APB write engine; a start seen in ACCESS chains the next
//           transfer with no idle cycle in between.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_apb_write_port
  import ecc_apb_driver_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_start,
  input  wire logic [AMBA_ADDR_WIDTH-1:0] i_addr,
  input  wire logic [AMBA_WORD-1:0]       i_data,
  output logic                            o_psel,
  output logic                            o_penable,
  output logic                            o_pwrite,
  output logic [AMBA_ADDR_WIDTH-1:0]      o_paddr,
  output logic [AMBA_WORD-1:0]            o_pwdata,
  output logic                            o_done
);

  wp_phase_t                  r_phase;
  logic                       r_psel;
  logic                       r_penable;
  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic [AMBA_WORD-1:0]       r_pwdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase   <= WP_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      case (r_phase)
        WP_SETUP: begin
          r_phase   <= WP_ACCESS;
          r_penable <= 1'b1;
        end
        default: begin
          r_penable <= 1'b0;
          if (i_start) begin
            r_phase  <= WP_SETUP;
            r_psel   <= 1'b1;
            r_paddr  <= i_addr;
            r_pwdata <= i_data;
          end else begin
            r_phase <= WP_IDLE;
            r_psel  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_psel;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;
  assign o_done    = (r_phase == WP_ACCESS);

endmodule

`default_nettype wire

// File: rtl/ecc_apb_driver.sv
// ============================================================================
// Module  : ecc_apb_driver
// Brief   : Runs one command through the ECC block over APB and returns the
//           captured result, timeout or illegal-command status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_apb_driver
  import ecc_apb_driver_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int BASE_ADDR       = 0,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input wire logic          clk,
  input wire logic          rst,
  ecc_apb_driver_if.master  bus
);

  localparam int                     c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AMBA_ADDR_WIDTH-1:0] c_BASE = AMBA_ADDR_WIDTH'(BASE_ADDR);

  state_t                r_state;
  logic [1:0]            r_idx;
  logic [1:0]            r_mode;
  logic [1:0]            r_width;
  logic [AMBA_WORD-1:0]  r_data;
  logic [AMBA_WORD-1:0]  r_noise;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [1:0]            r_res_errors;
  logic [1:0]            r_res_status;

  logic                       w_legal;
  logic                       w_last;
  logic                       w_start;
  logic                       w_wp_done;
  logic [1:0]                 w_off;
  logic [AMBA_WORD-1:0]       w_wdata;
  logic [AMBA_ADDR_WIDTH-1:0] w_addr;
  logic                       w_psel;
  logic                       w_penable;
  logic                       w_pwrite;
  logic [AMBA_ADDR_WIDTH-1:0] w_paddr;
  logic [AMBA_WORD-1:0]       w_pwdata;

  assign w_legal = (bus.cmd_mode != c_MODE_ILLEGAL) && (bus.cmd_width != c_WIDTH_ILLEGAL);
  assign w_last  = (r_idx == c_REG_CTRL);
  assign w_start = ((r_state == ST_IDLE) && bus.cmd_valid && w_legal) ||
                   ((r_state == ST_ACCESS) && w_wp_done && !w_last);

  // In IDLE the first write comes straight from the command inputs so that
  // SETUP is on the bus in the cycle right after accept.
  always_comb begin
    w_off   = c_REG_CODEWORD_WIDTH;
    w_wdata = AMBA_WORD'(bus.cmd_width);
    if (r_state != ST_IDLE) begin
      w_off = next_reg(r_idx, r_mode);
      case (w_off)
        c_REG_CODEWORD_WIDTH: w_wdata = AMBA_WORD'(r_width);
        c_REG_DATA_IN:        w_wdata = r_data;
        c_REG_NOISE:          w_wdata = r_noise;
        default:              w_wdata = AMBA_WORD'(r_mode);
      endcase
    end
  end

  assign w_addr = c_BASE | AMBA_ADDR_WIDTH'({w_off, 2'b00});

  ecc_apb_write_port #(
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
    .AMBA_WORD       (AMBA_WORD)
  ) u_write_port (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_addr    (w_addr),
    .i_data    (w_wdata),
    .o_psel    (w_psel),
    .o_penable (w_penable),
    .o_pwrite  (w_pwrite),
    .o_paddr   (w_paddr),
    .o_pwdata  (w_pwdata),
    .o_done    (w_wp_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= c_REG_CODEWORD_WIDTH;
      r_mode       <= '0;
      r_width      <= '0;
      r_data       <= '0;
      r_noise      <= '0;
      r_cnt        <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_errors <= '0;
      r_res_status <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_mode  <= bus.cmd_mode;
            r_width <= bus.cmd_width;
            r_data  <= bus.cmd_data;
            r_noise <= bus.cmd_noise;
            if (w_legal) begin
              r_state <= ST_SETUP;
              r_idx   <= c_REG_CODEWORD_WIDTH;
            end else begin
              r_state      <= ST_RESP;
              r_res_valid  <= 1'b1;
              r_res_data   <= '0;
              r_res_errors <= '0;
              r_res_status <= c_STATUS_ILLEGAL;
            end
          end
        end
        ST_SETUP: r_state <= ST_ACCESS;
        ST_ACCESS: begin
          if (w_wp_done) begin
            if (w_last) begin
              r_state <= ST_WAIT_DONE;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_SETUP;
              r_idx   <= w_off;
            end
          end
        end
        ST_WAIT_DONE: begin
          // A done pulse on the final counted cycle still counts as success.
          if (bus.operation_done) begin
            r_state      <= ST_RESP;
            r_res_valid  <= 1'b1;
            r_res_data   <= bus.data_out;
            r_res_errors <= bus.num_of_errors;
            r_res_status <= c_STATUS_OK;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state      <= ST_RESP;
            r_res_valid  <= 1'b1;
            r_res_data   <= '0;
            r_res_errors <= '0;
            r_res_status <= c_STATUS_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.PSEL       = w_psel;
  assign bus.PENABLE    = w_penable;
  assign bus.PWRITE     = w_pwrite;
  assign bus.PADDR      = w_paddr;
  assign bus.PWDATA     = w_pwdata;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_errors = r_res_errors;
  assign bus.res_status = r_res_status;

endmodule

`default_nettype wire

// File: doc/ecc_apb_driver.md
Name: ecc_apb_driver

Overview:
APB initiator that drives one command through the ECC encoder/decoder register block. It accepts a command on a valid/ready interface, performs the APB register writes in a fixed order, and waits for the operation_done pulse from the ECC block. It then returns data_out and num_of_errors as a result on a second valid/ready interface. It sits between a test sequencer or CPU-side controller and the APB port of the ECC block.

Parameters:
DATA_WIDTH, 32, width of the ECC block's data_out
AMBA_ADDR_WIDTH, 20, PADDR width
AMBA_WORD, 32, PWDATA and command data/noise width
BASE_ADDR, 0, ECC block base address; register offset is placed in PADDR[3:2], PADDR[1:0] is 0
TIMEOUT_CYCLES, 15, maximum WAIT_DONE cycles before status is timeout (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_mode  in  2  CTRL value: 00 encode, 01 decode, 10 full channel, 11 illegal
cmd_width  in  2  CODEWORD_WIDTH value: 00 small, 01 medium, 10 large, 11 illegal
cmd_data  in  AMBA_WORD  DATA_IN value
cmd_noise  in  AMBA_WORD  NOISE value
PADDR  out  AMBA_ADDR_WIDTH  APB address
PWDATA  out  AMBA_WORD  APB write data
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
data_out  in  DATA_WIDTH  ECC result
operation_done  in  1  ECC one-cycle done pulse
num_of_errors  in  2  ECC error count
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  DATA_WIDTH  captured data_out
res_errors  out  2  captured num_of_errors
res_status  out  2  00 ok, 01 timeout, 10 illegal command
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0 except cmd_ready=1; captured command and counters cleared; any in-flight APB transfer is abandoned.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE: command accepted when cmd_valid & cmd_ready; all cmd_* fields are registered on that edge.
  - If cmd_mode==11 or cmd_width==11: go directly to RESP with status 10, res_data 0, res_errors 0, and no APB traffic.
  - Otherwise go to SETUP with write index set to CODEWORD_WIDTH.
- Write sequence: CODEWORD_WIDTH (offset 10), DATA_IN (01), NOISE (11, issued only when mode==10), CTRL (00, always last because the CTRL write starts the ECC block).
- PWDATA is zero-extended: {30'b0,width} for CODEWORD_WIDTH, {30'b0,mode} for CTRL.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR and PWDATA valid; always one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1, with PADDR, PWDATA and PWRITE held stable. There is no PREADY, so ACCESS is always one cycle. Next state is SETUP for the next register, or WAIT_DONE after CTRL.
- Outside SETUP/ACCESS: PSEL=PENABLE=PWRITE=0; PADDR and PWDATA hold their last values.
- Transfers are back-to-back with no idle cycle between them. The CTRL ACCESS cycle occurs 6 cycles after accept for modes 00/01 and 8 cycles for mode 10.
- WAIT_DONE: cycle counter starts at 0 and increments each cycle.
  - operation_done=1 in any WAIT_DONE cycle: capture data_out and num_of_errors on that edge, status 00, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: status 01, res_data 0, res_errors 0, go to RESP.
  - Done on the last counted cycle wins over timeout.
- operation_done outside WAIT_DONE is ignored.
- RESP: res_valid=1 and res_data/res_errors/res_status are held stable until res_ready. On the res_valid & res_ready edge: res_valid=0, return to IDLE; cmd_ready rises in the following cycle. There is no bypass of a new command in the same cycle.
- res_data, res_errors and res_status keep their values after the handshake until the next capture.

Decomposition:
- Shared package: register offset constants (CTRL=2'b00, DATA_IN=2'b01, CODEWORD_WIDTH=2'b10, NOISE=2'b11), mode codes, width codes, status codes, state encoding.
- One natural sub-module, ecc_apb_write_port: a two-phase APB write engine (start/addr/data in, done out). The top level keeps the sequencing, timeout and result logic.

Test Plan:
- Encode, width 00, data 0x5, res_ready=1 -> APB writes to offsets 10,01,00 only with PWDATA 0,5,0. CTRL ACCESS 6 cycles after accept. Result captured in the cycle operation_done=1. res_status 00.
- Full channel, width 01, noise 0x0004 -> four transfers with NOISE before CTRL. res_errors equals num_of_errors (01) at the done pulse.
- ECC model never pulses done, TIMEOUT_CYCLES=15 -> res_valid exactly 15 cycles after entering WAIT_DONE, res_status 01, res_data 0.
- cmd_mode=11 -> no PSEL activity; res_valid the cycle after accept, res_status 10.
- res_ready held 0 for 5 cycles -> res_* stable throughout, cmd_ready low; cmd_ready high the cycle after the handshake.
- rst asserted during the DATA_IN ACCESS cycle -> PSEL/PENABLE drop immediately; after release cmd_ready=1 and a new command completes normally.
